// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access sequencer: one req/ack RAM transaction per load/store,
// byte-lane placement for stores, sign/zero extension for loads, stall and timeout abort.
module mem_access_ctrl #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  input  logic              is_store_i,
  input  logic [2:0]        funct3_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] store_data_i,
  input  logic [4:0]        rd_addr_i,
  output logic              stall_o,
  output logic              dram_req_o,
  output logic              dram_we_o,
  output logic [ADDR_W-1:0] dram_addr_o,
  output logic [3:0]        dram_be_o,
  output logic [DATA_W-1:0] dram_wdata_o,
  input  logic              dram_ack_i,
  input  logic [DATA_W-1:0] dram_rdata_i,
  output logic              load_valid_o,
  output logic [DATA_W-1:0] load_data_o,
  output logic [4:0]        load_rd_addr_o,
  output logic              fault_o,
  output logic              timeout_o
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam int unsigned     CNT_W   = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_funct3;
  logic [1:0]        r_off;
  logic [4:0]        r_rd;

  logic [1:0]        w_off;
  logic              w_fault;
  logic [3:0]        w_be;
  logic [DATA_W-1:0] w_wdata;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [DATA_W-1:0] w_ldata;

  assign w_off = addr_i[1:0];

  // Alignment/funct3 check and store lane placement; loads always read the full word.
  always_comb begin
    w_fault = 1'b0;
    w_be    = 4'b1111;
    w_wdata = store_data_i;
    case (funct3_i)
      3'b000: begin
        w_be    = 4'b0001 << w_off;
        w_wdata = {4{store_data_i[7:0]}};
      end
      3'b001: begin
        w_fault = w_off[0];
        w_be    = w_off[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{store_data_i[15:0]}};
      end
      3'b010:         w_fault = |w_off;
      3'b100, 3'b101: w_fault = is_store_i | (funct3_i[0] & w_off[0]);
      default:        w_fault = 1'b1;
    endcase
    if (!is_store_i) w_be = 4'b1111;
  end

  always_comb begin
    w_byte  = dram_rdata_i[{r_off, 3'b000} +: 8];
    w_half  = dram_rdata_i[{r_off[1], 4'b0000} +: 16];
    w_ldata = dram_rdata_i;
    case (r_funct3)
      3'b000:  w_ldata = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_ldata = {{16{w_half[15]}}, w_half};
      3'b100:  w_ldata = {24'd0, w_byte};
      3'b101:  w_ldata = {16'd0, w_half};
      default: w_ldata = dram_rdata_i;
    endcase
  end

  always_comb begin
    case (r_state)
      IDLE:    stall_o = req_valid_i & ~w_fault;
      REQ:     stall_o = 1'b1;
      default: stall_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_funct3       <= '0;
      r_off          <= '0;
      r_rd           <= '0;
      dram_req_o     <= 1'b0;
      dram_we_o      <= 1'b0;
      dram_addr_o    <= '0;
      dram_be_o      <= '0;
      dram_wdata_o   <= '0;
      load_valid_o   <= 1'b0;
      load_data_o    <= '0;
      load_rd_addr_o <= '0;
      fault_o        <= 1'b0;
      timeout_o      <= 1'b0;
    end else begin
      load_valid_o <= 1'b0;
      fault_o      <= 1'b0;
      timeout_o    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_valid_i) begin
            if (w_fault) begin
              fault_o <= 1'b1;
            end else begin
              dram_req_o   <= 1'b1;
              dram_we_o    <= is_store_i;
              dram_addr_o  <= {addr_i[ADDR_W-1:2], 2'b00};
              dram_be_o    <= w_be;
              dram_wdata_o <= w_wdata;
              r_funct3     <= funct3_i;
              r_off        <= w_off;
              r_rd         <= rd_addr_i;
              r_cnt        <= '0;
              r_state      <= REQ;
            end
          end
        end
        REQ: begin
          r_cnt <= r_cnt + 1'b1;
          // An ack on the final counted cycle still completes normally.
          if (dram_ack_i) begin
            dram_req_o <= 1'b0;
            if (!dram_we_o) begin
              load_valid_o   <= 1'b1;
              load_data_o    <= w_ldata;
              load_rd_addr_o <= r_rd;
            end
            r_state <= DONE;
          end else if (r_cnt == CNT_MAX) begin
            dram_req_o <= 1'b0;
            timeout_o  <= 1'b1;
            r_state    <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: vector table driven through a scoreboard queue,
// plus hand sequences for reset-during-request and ack outside a transaction.
`timescale 1ns/1ps
module tb_mem_access_ctrl;

  localparam int unsigned TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        is_store_i = 1'b0;
  logic [2:0]  funct3_i = '0;
  logic [31:0] addr_i = '0;
  logic [31:0] store_data_i = '0;
  logic [4:0]  rd_addr_i = '0;
  logic        stall_o;
  logic        dram_req_o;
  logic        dram_we_o;
  logic [31:0] dram_addr_o;
  logic [3:0]  dram_be_o;
  logic [31:0] dram_wdata_o;
  logic        dram_ack_i = 1'b0;
  logic [31:0] dram_rdata_i = '0;
  logic        load_valid_o;
  logic [31:0] load_data_o;
  logic [4:0]  load_rd_addr_o;
  logic        fault_o;
  logic        timeout_o;

  mem_access_ctrl #(.DATA_W(32), .ADDR_W(32), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid_i), .is_store_i(is_store_i),
    .funct3_i(funct3_i), .addr_i(addr_i), .store_data_i(store_data_i), .rd_addr_i(rd_addr_i),
    .stall_o(stall_o), .dram_req_o(dram_req_o), .dram_we_o(dram_we_o),
    .dram_addr_o(dram_addr_o), .dram_be_o(dram_be_o), .dram_wdata_o(dram_wdata_o),
    .dram_ack_i(dram_ack_i), .dram_rdata_i(dram_rdata_i), .load_valid_o(load_valid_o),
    .load_data_o(load_data_o), .load_rd_addr_o(load_rd_addr_o), .fault_o(fault_o),
    .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [4:0]  rd;
    logic [31:0] rdata;
    int          ack_dly;
    logic        e_fault;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    int          e_stalls;
    int          e_reqc;
    logic        e_lv;
    logic [31:0] e_ld;
    logic        e_to;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [4:0] rd, input logic [31:0] rdata,
                              input int ack_dly, input logic e_fault, input logic [3:0] e_be,
                              input logic [31:0] e_wd, input int e_stalls, input int e_reqc,
                              input logic e_lv, input logic [31:0] e_ld, input logic e_to);
    vec_t v;
    v.st = st; v.f3 = f3; v.addr = addr; v.wd = wd; v.rd = rd; v.rdata = rdata;
    v.ack_dly = ack_dly; v.e_fault = e_fault; v.e_be = e_be; v.e_wd = e_wd;
    v.e_stalls = e_stalls; v.e_reqc = e_reqc; v.e_lv = e_lv; v.e_ld = e_ld; v.e_to = e_to;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    vec_t        e;
    int          stalls = 0, reqc = 0, nf = 0, nlv = 0, nto = 0;
    logic [31:0] ld = '0, iaddr = '0, iwd = '0;
    logic [4:0]  lrd = '0;
    logic [3:0]  ibe = '0;
    logic        iwe = 1'b0, seen = 1'b0, s;
    sb.push_back(v);
    @(negedge clk);
    req_valid_i = 1'b1; is_store_i = v.st; funct3_i = v.f3; addr_i = v.addr;
    store_data_i = v.wd; rd_addr_i = v.rd;
    #1 s = stall_o;
    if (s) stalls++;
    for (int c = 0; c < int'(TMO) + 4; c++) begin
      @(negedge clk);
      if (!s) req_valid_i = 1'b0;
      if (dram_req_o) begin
        if (!seen) begin
          iaddr = dram_addr_o; ibe = dram_be_o; iwe = dram_we_o; iwd = dram_wdata_o; seen = 1'b1;
        end
        dram_ack_i = (reqc == v.ack_dly);
        dram_rdata_i = v.rdata;
        reqc++;
      end else begin
        dram_ack_i = 1'b0;
      end
      if (fault_o) nf++;
      if (timeout_o) nto++;
      if (load_valid_o) begin
        nlv++; ld = load_data_o; lrd = load_rd_addr_o;
      end
      #1 s = stall_o;
      if (s) stalls++;
    end
    dram_ack_i = 1'b0;
    req_valid_i = 1'b0;
    e = sb.pop_front();
    chk($sformatf("v%0d.fault_pulses", idx), 32'(nf), e.e_fault ? 32'd1 : 32'd0);
    chk($sformatf("v%0d.req_cycles", idx), 32'(reqc), 32'(e.e_reqc));
    chk($sformatf("v%0d.stall_cycles", idx), 32'(stalls), 32'(e.e_stalls));
    chk($sformatf("v%0d.load_valid_pulses", idx), 32'(nlv), e.e_lv ? 32'd1 : 32'd0);
    chk($sformatf("v%0d.timeout_pulses", idx), 32'(nto), e.e_to ? 32'd1 : 32'd0);
    if (!e.e_fault) begin
      chk($sformatf("v%0d.dram_addr", idx), iaddr, {e.addr[31:2], 2'b00});
      chk($sformatf("v%0d.dram_be", idx), 32'(ibe), 32'(e.e_be));
      chk($sformatf("v%0d.dram_we", idx), 32'(iwe), 32'(e.st));
      if (e.st) chk($sformatf("v%0d.dram_wdata", idx), iwd, e.e_wd);
    end
    if (e.e_lv) begin
      chk($sformatf("v%0d.load_data", idx), ld, e.e_ld);
      chk($sformatf("v%0d.load_rd", idx), 32'(lrd), 32'(e.rd));
    end
  endtask

  initial begin
    int bad;
    vecs.push_back(mk(0, 3'b010, 32'h100, 0, 5,  32'hDEADBEEF, 0, 0, 4'hF, 0, 2, 1, 1, 32'hDEADBEEF, 0));
    vecs.push_back(mk(0, 3'b000, 32'h103, 0, 7,  32'h80112233, 1, 0, 4'hF, 0, 3, 2, 1, 32'hFFFFFF80, 0));
    vecs.push_back(mk(0, 3'b100, 32'h103, 0, 8,  32'h80112233, 0, 0, 4'hF, 0, 2, 1, 1, 32'h00000080, 0));
    vecs.push_back(mk(0, 3'b101, 32'h102, 0, 9,  32'h80112233, 2, 0, 4'hF, 0, 4, 3, 1, 32'h00008011, 0));
    vecs.push_back(mk(0, 3'b001, 32'h102, 0, 10, 32'h80112233, 0, 0, 4'hF, 0, 2, 1, 1, 32'hFFFF8011, 0));
    vecs.push_back(mk(0, 3'b001, 32'h100, 0, 11, 32'h80112233, 0, 0, 4'hF, 0, 2, 1, 1, 32'h00002233, 0));
    vecs.push_back(mk(0, 3'b000, 32'h101, 0, 12, 32'h80112233, 0, 0, 4'hF, 0, 2, 1, 1, 32'h00000022, 0));
    vecs.push_back(mk(1, 3'b000, 32'h201, 32'h000000A5, 0, 0, 0, 0, 4'b0010, 32'hA5A5A5A5, 2, 1, 0, 0, 0));
    vecs.push_back(mk(1, 3'b001, 32'h202, 32'h00001234, 0, 0, 0, 0, 4'b1100, 32'h12341234, 2, 1, 0, 0, 0));
    vecs.push_back(mk(1, 3'b010, 32'h204, 32'hCAFEF00D, 0, 0, 1, 0, 4'b1111, 32'hCAFEF00D, 3, 2, 0, 0, 0));
    vecs.push_back(mk(1, 3'b000, 32'h203, 32'h1234567E, 0, 0, 0, 0, 4'b1000, 32'h7E7E7E7E, 2, 1, 0, 0, 0));
    vecs.push_back(mk(1, 3'b001, 32'h200, 32'h9999ABCD, 0, 0, 0, 0, 4'b0011, 32'hABCDABCD, 2, 1, 0, 0, 0));
    vecs.push_back(mk(0, 3'b010, 32'h102, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 3'b001, 32'h101, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 3'b011, 32'h100, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 3'b100, 32'h100, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 3'b101, 32'h103, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 3'b010, 32'h300, 0, 3, 32'h55555555, 99, 0, 4'hF, 0, 5, 4, 0, 0, 1));
    vecs.push_back(mk(0, 3'b010, 32'h304, 0, 4, 32'h0BADF00D, 3, 0, 4'hF, 0, 5, 4, 1, 32'h0BADF00D, 0));
    vecs.push_back(mk(1, 3'b010, 32'h308, 32'h11223344, 0, 0, 99, 0, 4'hF, 32'h11223344, 5, 4, 0, 0, 1));

    #12;
    chk("rst.dram_req", 32'(dram_req_o), 0);
    chk("rst.dram_we", 32'(dram_we_o), 0);
    chk("rst.dram_be", 32'(dram_be_o), 0);
    chk("rst.dram_addr", dram_addr_o, 0);
    chk("rst.dram_wdata", dram_wdata_o, 0);
    chk("rst.load_valid", 32'(load_valid_o), 0);
    chk("rst.load_data", load_data_o, 0);
    chk("rst.load_rd", 32'(load_rd_addr_o), 0);
    chk("rst.fault", 32'(fault_o), 0);
    chk("rst.timeout", 32'(timeout_o), 0);
    chk("rst.stall", 32'(stall_o), 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Ack while idle must not start or complete anything.
    bad = 0;
    @(negedge clk);
    dram_ack_i = 1'b1; dram_rdata_i = 32'hFFFFFFFF;
    repeat (3) begin
      @(negedge clk);
      if (load_valid_o || dram_req_o || timeout_o || stall_o) bad++;
    end
    dram_ack_i = 1'b0;
    chk("idle_ack.activity", 32'(bad), 0);

    // Reset asserted during the second REQ cycle.
    @(negedge clk);
    req_valid_i = 1'b1; is_store_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h400; rd_addr_i = 5'd9;
    @(negedge clk);
    chk("rstreq.req_cycle1", 32'(dram_req_o), 1);
    @(negedge clk);
    chk("rstreq.req_cycle2", 32'(dram_req_o), 1);
    #1 rst_n = 1'b0; req_valid_i = 1'b0;
    #1;
    chk("rstreq.req_dropped", 32'(dram_req_o), 0);
    chk("rstreq.stall", 32'(stall_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (TMO + 3) begin
      @(negedge clk);
      if (load_valid_o || timeout_o || fault_o || dram_req_o || stall_o) bad++;
    end
    chk("rstreq.no_pulses", 32'(bad), 0);

    run_vec(vecs[0], 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Sequences data-memory accesses for the MEM stage of the RV32I pipeline. It issues one data-RAM transaction per load/store with a req/ack handshake, generates byte enables and store-data lane placement, and sign- or zero-extends load data. It holds the pipeline with a stall while the access is outstanding. Its load result and destination register feed the MEM/WB write-back and forwarding path.

Parameters:
DATA_W, 32, data and register width; only 32 is supported.
ADDR_W, 32, byte address width.
TIMEOUT_CYC, 64, number of cycles to wait for dram_ack_i before aborting; must be at least 2.

Ports:
clk  in  1  system clock; all state changes on its rising edge.
rst_n  in  1  asynchronous, active-low reset.
req_valid_i  in  1  MEM stage holds a load or store this cycle.
is_store_i  in  1  1 = store, 0 = load.
funct3_i  in  3  access width and sign selector.
addr_i  in  ADDR_W  effective byte address.
store_data_i  in  DATA_W  rs2 value for the store.
rd_addr_i  in  5  load destination register.
stall_o  out  1  freeze IF through MEM; combinational.
dram_req_o  out  1  transaction request; registered.
dram_we_o  out  1  write enable; registered.
dram_addr_o  out  ADDR_W  word address, addr_i with bits [1:0] forced to 0; registered.
dram_be_o  out  4  byte enables; registered.
dram_wdata_o  out  DATA_W  lane-placed store data; registered.
dram_ack_i  in  1  RAM completes the transaction; dram_rdata_i is valid in the same cycle.
dram_rdata_i  in  DATA_W  read word.
load_valid_o  out  1  one-cycle pulse: load_data_o is ready to write back.
load_data_o  out  DATA_W  extended load result; registered.
load_rd_addr_o  out  5  destination register for load_data_o; registered.
fault_o  out  1  one-cycle pulse for a misaligned access or unsupported funct3.
timeout_o  out  1  one-cycle pulse when an access is aborted.

Behaviour:
- Reset (asynchronous, active-low): state goes to IDLE immediately. dram_req_o, dram_we_o, dram_be_o, load_valid_o, fault_o and timeout_o become 0. dram_addr_o, dram_wdata_o, load_data_o and load_rd_addr_o become 0. The timeout counter clears. Reset during REQ drops dram_req_o at once; no completion or pulse follows.
- Supported funct3 values:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other value is unsupported.
- Fault check (IDLE only): a halfword access with addr_i[0]=1, a word access with addr_i[1:0]≠0, or an unsupported funct3 is a fault.
  - Next cycle: fault_o=1 for one cycle.
  - No RAM transaction is issued and stall_o stays 0.
- FSM states: IDLE, REQ, DONE.
  - IDLE: stall_o = req_valid_i & ~fault. On a valid non-faulting request, register the RAM outputs, set dram_req_o=1, clear the counter and go to REQ.
  - REQ: stall_o=1 and dram_req_o is held with stable outputs. The counter increments every cycle.
    - dram_ack_i=1: capture the extended read data for a load, deassert dram_req_o, go to DONE.
    - Counter reaches TIMEOUT_CYC-1 without ack: deassert dram_req_o, set the abort flag, go to DONE.
    - An ack in the same cycle the counter reaches TIMEOUT_CYC-1 wins over the timeout.
  - DONE: stall_o=0, so the pipeline advances at the end of this cycle.
    - load_valid_o=1 for a completed load; load_valid_o=0 for a store or an aborted access.
    - timeout_o=1 if the access was aborted.
    - req_valid_i is ignored. The next state is always IDLE.
- Latency: dram_req_o rises 1 cycle after the request. If ack arrives in the first REQ cycle, DONE is cycle 2, giving 2 stall cycles. Otherwise stall cycles = 1 + cycles until ack. An abort gives TIMEOUT_CYC+1 stall cycles.
- Store lane placement (o = addr_i[1:0]):
  - SB: be = 1<<o, wdata = store byte replicated ×4.
  - SH: be = 0011 when o=0, 1100 when o=2; wdata = store halfword replicated ×2.
  - SW: be = 1111, wdata = store_data_i.
- Loads: dram_be_o=1111 and dram_we_o=0. The selected byte or halfword is taken at offset o. LB and LH sign-extend; LBU and LHU zero-extend.
- dram_ack_i outside REQ is ignored.

Test Plan:
- LW addr 0x100, ack 1 cycle after req, rdata 0xDEADBEEF, rd=5 -> stall_o high for 2 cycles; dram_addr_o=0x100, be=1111, we=0; DONE cycle: load_valid_o=1, load_data_o=0xDEADBEEF, load_rd_addr_o=5.
- LB addr 0x103, rdata 0x80112233 -> load_data_o=0xFFFFFF80. LBU same -> 0x00000080. LHU addr 0x102 -> 0x00008011.
- SB addr 0x201, data 0x000000A5 -> be=0010, wdata=0xA5A5A5A5, we=1. SH addr 0x202, data 0x1234 -> be=1100, wdata=0x12341234. In both cases load_valid_o stays 0.
- LW addr 0x102; SH addr 0x101; funct3=011 -> fault_o pulses once each, dram_req_o stays 0, stall_o stays 0.
- No ack with TIMEOUT_CYC=4 -> dram_req_o high 4 cycles, then drops; timeout_o=1 in DONE; load_valid_o=0; 5 stall cycles. Ack arriving on the 4th REQ cycle -> normal completion, no timeout_o.
- rst_n low during the 2nd REQ cycle -> dram_req_o drops immediately. After release, state is IDLE and no load_valid_o or timeout_o pulse occurs.
